// File: rtl/spi_uart_bridge.sv
// SPI master for an external SPI UART: writes queued send bytes, polls the
// chip for received bytes and holds them for the CPU until it reads them.
module spi_uart_bridge #(
  parameter int SCK_DIV       = 4,
  parameter int POLL_INTERVAL = 256
) (
  input  logic       MCLK_IN,
  input  logic       RESET_IN,
  input  logic       UART_SEND_TRIGGER_IN,
  input  logic [7:0] UART_SEND_BYTE_IN,
  input  logic       UART_RECEIVE_CAPTURE_IN,
  output logic       UART_SEND_BUSY,
  output logic       UART_RECEIVED,
  output logic [7:0] UART_RECEIVE_BYTE,
  output logic       SPI_CS_N,
  output logic       SPI_SCK,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO_IN
);
  localparam int DIV_W  = $clog2(SCK_DIV);
  localparam int POLL_W = $clog2(POLL_INTERVAL + 1);
  localparam logic [1:0] CMD_READ   = 2'b00;
  localparam logic [1:0] CMD_STATUS = 2'b01;
  localparam logic [1:0] CMD_WRITE  = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT_HI, S_SHIFT_LO, S_HOLD} state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [3:0]        bit_q;
  logic [POLL_W-1:0] poll_q;
  logic [15:0]       shreg_q;
  logic [1:0]        cmd_q;
  logic [7:0]        rx_q;
  logic              r_flag_q, t_flag_q;
  logic              txempty_q, busy_q, received_q;
  logic [7:0]        pend_q, rbyte_q;
  logic              trig_prev_q, cap_prev_q;
  logic              cs_n_q, sck_q;

  logic        div_done, trig_rise, cap_fall, start_write, start_read;
  logic [1:0]  cmd_d;
  logic [15:0] frame_d;

  // Status frames are used whenever the held byte must not be overwritten.
  always_comb begin
    div_done    = (div_q == DIV_W'(SCK_DIV - 1));
    trig_rise   = UART_SEND_TRIGGER_IN & ~trig_prev_q;
    cap_fall    = ~UART_RECEIVE_CAPTURE_IN & cap_prev_q;
    start_write = busy_q & txempty_q;
    start_read  = (poll_q >= POLL_W'(POLL_INTERVAL)) | (busy_q & ~txempty_q);
    if (start_write) begin
      cmd_d   = CMD_WRITE;
      frame_d = {CMD_WRITE, 6'b000000, pend_q};
    end else if (received_q | UART_RECEIVE_CAPTURE_IN) begin
      cmd_d   = CMD_STATUS;
      frame_d = {CMD_STATUS, 14'h0000};
    end else begin
      cmd_d   = CMD_READ;
      frame_d = {CMD_READ, 14'h0000};
    end
  end

  always_ff @(posedge MCLK_IN) begin
    if (RESET_IN) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= 4'd0;
      poll_q      <= '0;
      shreg_q     <= 16'h0000;
      cmd_q       <= CMD_READ;
      rx_q        <= 8'h00;
      r_flag_q    <= 1'b0;
      t_flag_q    <= 1'b0;
      txempty_q   <= 1'b0;
      busy_q      <= 1'b0;
      received_q  <= 1'b0;
      pend_q      <= 8'h00;
      rbyte_q     <= 8'h00;
      trig_prev_q <= 1'b0;
      cap_prev_q  <= 1'b0;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
    end else begin
      trig_prev_q <= UART_SEND_TRIGGER_IN;
      cap_prev_q  <= UART_RECEIVE_CAPTURE_IN;
      if (trig_rise && !busy_q) begin
        pend_q <= UART_SEND_BYTE_IN;
        busy_q <= 1'b1;
      end
      if (cap_fall) received_q <= 1'b0;

      if (state_q == S_IDLE || div_done) div_q <= '0;
      else                               div_q <= div_q + DIV_W'(1);

      case (state_q)
        S_IDLE: begin
          if (start_write || start_read) begin
            state_q <= S_SETUP;
            cs_n_q  <= 1'b0;
            poll_q  <= '0;
            bit_q   <= 4'd0;
            cmd_q   <= cmd_d;
            shreg_q <= frame_d;
          end else begin
            poll_q <= poll_q + POLL_W'(1);
          end
        end
        S_SETUP: begin
          if (div_done) begin
            state_q  <= S_SHIFT_HI;
            sck_q    <= 1'b1;
            r_flag_q <= SPI_MISO_IN;
            rx_q     <= {rx_q[6:0], SPI_MISO_IN};
          end
        end
        S_SHIFT_HI: begin
          if (div_done) begin
            state_q <= S_SHIFT_LO;
            sck_q   <= 1'b0;
            shreg_q <= {shreg_q[14:0], 1'b0};
          end
        end
        S_SHIFT_LO: begin
          if (div_done) begin
            if (bit_q == 4'd15) begin
              state_q <= S_HOLD;
            end else begin
              state_q <= S_SHIFT_HI;
              sck_q   <= 1'b1;
              bit_q   <= bit_q + 4'd1;
              rx_q    <= {rx_q[6:0], SPI_MISO_IN};
              if (bit_q == 4'd0) t_flag_q <= SPI_MISO_IN;
            end
          end
        end
        S_HOLD: begin
          if (div_done) begin
            state_q <= S_IDLE;
            cs_n_q  <= 1'b1;
            // A write fills the chip's buffer, so the old T flag is stale.
            if (cmd_q == CMD_WRITE) begin
              txempty_q <= 1'b0;
              busy_q    <= 1'b0;
            end else begin
              txempty_q <= t_flag_q;
            end
            if (cmd_q == CMD_READ && r_flag_q) begin
              rbyte_q    <= rx_q;
              received_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          cs_n_q  <= 1'b1;
          sck_q   <= 1'b0;
        end
      endcase
    end
  end

  assign UART_SEND_BUSY    = busy_q;
  assign UART_RECEIVED     = received_q;
  assign UART_RECEIVE_BYTE = rbyte_q;
  assign SPI_CS_N          = cs_n_q;
  assign SPI_SCK           = sck_q;
  assign SPI_MOSI          = shreg_q[15];
endmodule
